sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Arbitrates the SDRAM_16bit command port between the video refill path and the cache controller.
//  Grants video FIFO refill first, then cache write-back, then cache line fill.
//  Generates the SDRAM word address, including a wrapping framebuffer pointer.
//  Steers read beats to the video queue, packed 2x16 -> 32 bits, or to the cache fill port.
//  Sits in the clk_sdr domain, between cache_controller/vqueue upstream and SDRAM_16bit downstream.
// PARAMETERS
//  VID_BURSTS    3072     32-byte video bursts per frame; pointer wraps VID_BURSTS-1 -> 0
//  VID_BASE_BLK  15'h6FF8 framebuffer base, in 8-word units
//  VID_BEATS     16       16-bit beats per video read (32 bytes)
//  CACHE_BEATS   128      16-bit beats per cache line transfer (256 bytes)
//  FAIR_LIMIT    8        max consecutive video grants while cache is waiting (ARB_FAIR_EN only)
// PORTS
//  clk               in   1  SDRAM clock; all logic on posedge
//  rst               in   1  asynchronous, active-low reset
//  vq_almost_empty   in   1  video queue requests a refill
//  vid_restart       in   1  frame resync pulse (vsync edge); pointer -> 0 at next IDLE
//  cache_wr_req      in   1  cache has a dirty line to write back
//  cache_rd_req      in   1  cache miss; line fill needed
//  cache_waddr       in   12 write-back line address (256-byte units)
//  cache_raddr       in   12 fill line address (CPU adr[19:8])
//  sys_cmd           out  2  00 nop, 01 wr256, 10 rd32, 11 rd256
//  sys_addr          out  18 SDRAM word address for sys_cmd
//  sys_cmd_ack       in   2  controller echoes the accepted command code for 1 cycle
//  sys_rd_data_valid in   1  read beat present on sys_dout
//  sys_wr_data_valid in   1  controller consumes one write beat
//  sys_dout          in   16 read data
//  vq_data           out  32 {second beat, first beat}
//  vq_wr             out  1  1-cycle write strobe to the video queue
//  cache_fill_we     out  1  = sys_rd_data_valid while a cache read is owned
//  cache_drain_re    out  1  = sys_wr_data_valid while a cache write is owned
// BEHAVIOUR
//  Reset values: sys_cmd=00, vq_wr=0, vq_data=0, vid_ptr=0, beat=0, state=IDLE.
//    cache_fill_we and cache_drain_re are 0 in reset.
//  FSM: IDLE -> REQ -> XFER -> IDLE. Exactly one command is outstanding at any time.
//  IDLE: samples requests. Priority: vq_almost_empty > cache_wr_req > cache_rd_req.
//    On a grant, registers sys_cmd/sys_addr (visible next cycle) and moves to REQ.
//  sys_addr per command:
//    10: {VID_BASE_BLK + {3'b0, ~vid_ptr[11:2], vid_ptr[1:0]}, 3'b000}
//    01: {cache_waddr, 6'b0}
//    11: {cache_raddr, 6'b0}
//  REQ: holds sys_cmd/sys_addr stable until sys_cmd_ack == sys_cmd.
//    On the ack, sys_cmd -> 00 (next cycle) and the FSM moves to XFER with beat=0.
//    If the ack is for video, vid_ptr advances, wrapping at VID_BURSTS-1.
//    A non-matching nonzero ack is ignored.
//  XFER: each valid beat (rd or wr, per owner) increments beat.
//    Returns to IDLE on the beat == VID_BEATS-1 or CACHE_BEATS-1 valid beat.
//    Valid strobes outside XFER are dropped; no outputs fire.
//  Video packing: odd beats latch the low half; even beats drive vq_data and pulse vq_wr for 1 cycle.
//    Result: 8 vq_wr per video burst.
//  vid_restart: pending flag, set on the pulse and held until applied.
//    Applied only in IDLE before arbitration: vid_ptr <= 0, flag cleared.
//    Never applied mid-burst.
//  Simultaneous requests: a request arriving in REQ/XFER waits; nothing is queued beyond the level inputs.
//  Reset mid-transfer: returns to IDLE at once; in-flight beats are discarded. The controller is reset in step.
//  A request dropped while in REQ does not cancel the command; the transfer completes.
// CONFIGURATION
//  ARB_FAIR_EN defined:
//    A 4-bit counter counts consecutive video grants made while cache_wr_req|cache_rd_req is high.
//    At FAIR_LIMIT, the next IDLE grant goes to the cache.
//    The counter clears on any cache grant.
//  ARB_FAIR_EN undefined: strict priority; the counter is not built.
// TESTING
//  1. Priority: raise vq_almost_empty, cache_wr_req and cache_rd_req together ->
//     sys_cmd=10 first; 01 only after 16 rd beats; then 11.
//  2. Packing: video burst with beats 16'h0001..16'h0010 -> 8 vq_wr pulses;
//     first vq_data=32'h0002_0001, last vq_data=32'h0010_000F.
//  3. Wrap: preload vid_ptr=3071 and run one video burst -> sys_addr={15'h6FF8+15'h0FFF... per formula, 3'b0}; vid_ptr=0.
//     vid_restart mid-burst -> vid_ptr=0 only after the burst completes.
//  4. Write-back: cache_waddr=12'hABC -> sys_addr=18'h2AF00; cache_drain_re mirrors
//     exactly 128 sys_wr_data_valid pulses, then IDLE.
//  5. Reset: assert rst low at XFER beat 40 of a cache read -> outputs at reset values in the same cycle.
//     After release, the held cache_rd_req is re-granted.
//  6. ARB_FAIR_EN: hold vq_almost_empty and cache_rd_req high -> sys_cmd=11 after 8 consecutive 10 grants.
//     Without the macro, only 10 grants are issued.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Purpose : Bundles every signal between sdram_arbiter, its upstream clients
//           (video queue, cache controller) and the downstream SDRAM_16bit
//           command port. It also carries a small debug group that exposes
//           the arbiter's FSM state, beat counter and framebuffer pointer,
//           plus a pointer preload hook.
// Modports: slave  - the arbiter side (requests, ack and beats in; cmd/addr out)
//           master - the environment side (drives requests, ack and beats)
// Handshake semantics (the only flow-control contract on this port):
//   A command is offered by holding sys_cmd != 00 with a stable sys_addr. It is
//   accepted in the cycle where sys_cmd_ack equals sys_cmd. After that, data
//   moves one 16-bit beat per cycle in which sys_rd_data_valid (reads) or
//   sys_wr_data_valid (writes) is high; the arbiter never back-pressures a beat.
// Signals:
//   vq_almost_empty, vid_restart      video refill request / frame resync pulse
//   cache_wr_req, cache_rd_req        cache write-back / line-fill requests
//   cache_waddr, cache_raddr [11:0]   cache line addresses (256-byte units)
//   sys_cmd [1:0], sys_addr [17:0]    command and word address to the controller
//   sys_cmd_ack [1:0]                 controller echo of the accepted command
//   sys_rd_data_valid, sys_dout[15:0] read beat strobe and data
//   sys_wr_data_valid                 write beat consumed by the controller
//   vq_data [31:0], vq_wr             packed video word and its write strobe
//   cache_fill_we, cache_drain_re     beat strobes steered to the cache
//   dbg_ptr_ld, dbg_ptr_val [11:0]    framebuffer pointer preload (IDLE only)
//   dbg_state [1:0], dbg_vid_ptr, dbg_beat  observation of internal state
// -----------------------------------------------------------------------------
interface sdram_arbiter_if;
    logic        vq_almost_empty;
    logic        vid_restart;
    logic        cache_wr_req;
    logic        cache_rd_req;
    logic [11:0] cache_waddr;
    logic [11:0] cache_raddr;
    logic [1:0]  sys_cmd;
    logic [17:0] sys_addr;
    logic [1:0]  sys_cmd_ack;
    logic        sys_rd_data_valid;
    logic        sys_wr_data_valid;
    logic [15:0] sys_dout;
    logic [31:0] vq_data;
    logic        vq_wr;
    logic        cache_fill_we;
    logic        cache_drain_re;
    logic        dbg_ptr_ld;
    logic [11:0] dbg_ptr_val;
    logic [1:0]  dbg_state;
    logic [11:0] dbg_vid_ptr;
    logic [6:0]  dbg_beat;

    modport slave (
        input  vq_almost_empty, vid_restart, cache_wr_req, cache_rd_req,
               cache_waddr, cache_raddr, sys_cmd_ack, sys_rd_data_valid,
               sys_wr_data_valid, sys_dout, dbg_ptr_ld, dbg_ptr_val,
        output sys_cmd, sys_addr, vq_data, vq_wr, cache_fill_we, cache_drain_re,
               dbg_state, dbg_vid_ptr, dbg_beat
    );

    modport master (
        output vq_almost_empty, vid_restart, cache_wr_req, cache_rd_req,
               cache_waddr, cache_raddr, sys_cmd_ack, sys_rd_data_valid,
               sys_wr_data_valid, sys_dout, dbg_ptr_ld, dbg_ptr_val,
        input  sys_cmd, sys_addr, vq_data, vq_wr, cache_fill_we, cache_drain_re,
               dbg_state, dbg_vid_ptr, dbg_beat
    );
endinterface

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Purpose : Shares the SDRAM_16bit command port between the video refill path
//           and the cache controller. Priority is video refill, then cache
//           write-back, then cache line fill. Builds the SDRAM word address
//           (including a wrapping framebuffer pointer) and steers read beats
//           either to the video queue (packed 2x16 -> 32) or to the cache.
//           Exactly one command is outstanding: IDLE -> REQ -> XFER -> IDLE.
// Ports   : i_clk   - SDRAM clock, all logic on the rising edge
//           i_rst_n - asynchronous active-low reset
//           bus     - sdram_arbiter_if.slave (see interface header for signals)
// Config  : define ARB_FAIR_EN to bound consecutive video grants (FAIR_LIMIT)
//           while the cache is waiting; undefined gives strict priority.
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int          VID_BURSTS   = 3072,
    parameter logic [14:0] VID_BASE_BLK = 15'h6FF8,
    parameter int          VID_BEATS    = 16,
    parameter int          CACHE_BEATS  = 128,
    parameter int          FAIR_LIMIT   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sdram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    state_t      r_state;
    logic [1:0]  r_sys_cmd;
    logic [17:0] r_sys_addr;
    logic [1:0]  r_owner;        // command being transferred, kept after sys_cmd drops
    logic [11:0] r_vid_ptr;
    logic [6:0]  r_beat;
    logic [15:0] r_lo;           // first beat of the current video pair
    logic [31:0] r_vq_data;
    logic        r_vq_wr;
    logic        r_restart_pend;

    logic [11:0] w_ptr_eff;
    logic [14:0] w_vid_blk;
    logic        w_cache_wait;
    logic        w_fair_force;
    logic [1:0]  w_grant;
    logic        w_beat_valid;
    logic        w_last_beat;
    logic [11:0] w_ptr_next;

    // The pointer the IDLE grant will use: a preload or pending restart takes
    // effect before arbitration in the same cycle.
    assign w_ptr_eff = bus.dbg_ptr_ld ? bus.dbg_ptr_val :
                       (r_restart_pend ? 12'd0 : r_vid_ptr);

    // Inverting the upper pointer bits lays the frame out top-down from the base.
    assign w_vid_blk = VID_BASE_BLK + {3'b000, ~w_ptr_eff[11:2], w_ptr_eff[1:0]};

    assign w_cache_wait = bus.cache_wr_req | bus.cache_rd_req;

`ifdef ARB_FAIR_EN
    logic [3:0] r_fair_cnt;
    assign w_fair_force = (r_fair_cnt >= 4'(FAIR_LIMIT)) && w_cache_wait;
`else
    assign w_fair_force = 1'b0;
`endif

    always_comb begin
        w_grant = CMD_NOP;
        if (bus.vq_almost_empty && !w_fair_force) begin
            w_grant = CMD_RD32;
        end else if (bus.cache_wr_req) begin
            w_grant = CMD_WR256;
        end else if (bus.cache_rd_req) begin
            w_grant = CMD_RD256;
        end
    end

    assign w_beat_valid = (r_owner == CMD_WR256) ? bus.sys_wr_data_valid
                                                  : bus.sys_rd_data_valid;
    assign w_last_beat  = (r_owner == CMD_RD32) ? (r_beat == 7'(VID_BEATS - 1))
                                                : (r_beat == 7'(CACHE_BEATS - 1));
    assign w_ptr_next   = (r_vid_ptr == 12'(VID_BURSTS - 1)) ? 12'd0 : r_vid_ptr + 12'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_sys_cmd      <= CMD_NOP;
            r_sys_addr     <= '0;
            r_owner        <= CMD_NOP;
            r_vid_ptr      <= '0;
            r_beat         <= '0;
            r_lo           <= '0;
            r_vq_data      <= '0;
            r_vq_wr        <= 1'b0;
            r_restart_pend <= 1'b0;
`ifdef ARB_FAIR_EN
            r_fair_cnt     <= '0;
`endif
        end else begin
            r_vq_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_vid_ptr      <= w_ptr_eff;
                    r_restart_pend <= 1'b0;
                    if (w_grant != CMD_NOP) begin
                        r_sys_cmd <= w_grant;
                        r_owner   <= w_grant;
                        r_state   <= ST_REQ;
                        case (w_grant)
                            CMD_RD32:  r_sys_addr <= {w_vid_blk, 3'b000};
                            CMD_WR256: r_sys_addr <= {bus.cache_waddr, 6'b0};
                            default:   r_sys_addr <= {bus.cache_raddr, 6'b0};
                        endcase
`ifdef ARB_FAIR_EN
                        // Only unbroken runs of video grants against a waiting cache count.
                        if (w_grant == CMD_RD32) begin
                            r_fair_cnt <= w_cache_wait ? r_fair_cnt + 4'd1 : 4'd0;
                        end else begin
                            r_fair_cnt <= 4'd0;
                        end
`endif
                    end
                end
                ST_REQ: begin
                    // Any other ack value belongs to nobody here and is ignored.
                    if (bus.sys_cmd_ack == r_sys_cmd) begin
                        r_sys_cmd <= CMD_NOP;
                        r_beat    <= '0;
                        r_state   <= ST_XFER;
                        if (r_owner == CMD_RD32) begin
                            r_vid_ptr <= w_ptr_next;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_beat_valid) begin
                        r_beat <= r_beat + 7'd1;
                        if (r_owner == CMD_RD32) begin
                            // Beat counter is 0-based: even count = first of a pair.
                            if (!r_beat[0]) begin
                                r_lo <= bus.sys_dout;
                            end else begin
                                r_vq_data <= {bus.sys_dout, r_lo};
                                r_vq_wr   <= 1'b1;
                            end
                        end
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A pulse seen in IDLE is kept for the next IDLE visit.
            if (bus.vid_restart) begin
                r_restart_pend <= 1'b1;
            end
        end
    end

    assign bus.sys_cmd        = r_sys_cmd;
    assign bus.sys_addr       = r_sys_addr;
    assign bus.vq_data        = r_vq_data;
    assign bus.vq_wr          = r_vq_wr;
    assign bus.cache_fill_we  = (r_state == ST_XFER) && (r_owner == CMD_RD256) &&
                                bus.sys_rd_data_valid;
    assign bus.cache_drain_re = (r_state == ST_XFER) && (r_owner == CMD_WR256) &&
                                bus.sys_wr_data_valid;
    assign bus.dbg_state      = r_state;
    assign bus.dbg_vid_ptr    = r_vid_ptr;
    assign bus.dbg_beat       = r_beat;

endmodule
